// File: rtl/am_pkg.sv
// Alignment-marker constants and types shared by the 40GBASE-R marker
// inserter (TX) and marker lock (RX).
package am_pkg;

    localparam int unsigned AM_CNT_W = 14;
    localparam int unsigned AM_LANES = 4;

    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam logic [1:0] SYNC_DATA = 2'b01;

    typedef logic [1:0] lane_id_t;

    // Marker bytes packed so that m0 lands in byte 0 of the block payload.
    typedef struct packed {
        logic [7:0] m2;
        logic [7:0] m1;
        logic [7:0] m0;
    } am_marker_t;

    typedef enum logic [1:0] {
        ST_FIND      = 2'd0,
        ST_COUNT_2ND = 2'd1,
        ST_LOCKED    = 2'd2
    } am_state_t;

    function automatic am_marker_t am_marker(input lane_id_t lane);
        am_marker_t m;
        case (lane)
            2'd0:    m = '{m2: 8'h47, m1: 8'h76, m0: 8'h90};
            2'd1:    m = '{m2: 8'hE6, m1: 8'hC4, m0: 8'hF0};
            2'd2:    m = '{m2: 8'h9B, m1: 8'h65, m0: 8'hC5};
            default: m = '{m2: 8'h3D, m1: 8'h79, m0: 8'hA2};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/am_lock_rx_if.sv
// Block stream into and out of the marker lock, plus lock status.
interface am_lock_rx_if #(
    parameter int unsigned LANE_N = 4,
    parameter int unsigned HEAD_W = 2,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned LANE_W = (LANE_N > 1) ? $clog2(LANE_N) : 1;

    logic              valid_i;
    logic [HEAD_W-1:0] head_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic [HEAD_W-1:0] head_o;
    logic [DATA_W-1:0] data_o;
    logic              lock_o;
    logic [LANE_W-1:0] lane_o;
    logic              marker_v_o;

    modport master (
        output valid_i, head_i, data_i,
        input  valid_o, head_o, data_o, lock_o, lane_o, marker_v_o
    );

    modport slave (
        input  valid_i, head_i, data_i,
        output valid_o, head_o, data_o, lock_o, lane_o, marker_v_o
    );
endinterface

// File: rtl/am_match.sv
// Combinational alignment-marker detector: reports a hit and which lane's
// marker the block carries. BIP bytes 3 and 7 are not examined.
module am_match
    import am_pkg::*;
#(
    parameter int unsigned HEAD_W = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LANE_N = 4
) (
    input  logic [HEAD_W-1:0] i_head,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_hit,
    output lane_id_t          o_hit_lane
);

    logic w_ctrl;
    assign w_ctrl = (i_head == HEAD_W'(SYNC_CTRL));

    always_comb begin
        o_hit      = 1'b0;
        o_hit_lane = '0;
        for (int l = 0; l < int'(LANE_N); l++) begin
            if (w_ctrl &&
                i_data[23:0]  ==  am_marker(lane_id_t'(l)) &&
                i_data[55:32] == ~am_marker(lane_id_t'(l))) begin
                o_hit      = 1'b1;
                o_hit_lane = lane_id_t'(l);
            end
        end
    end

endmodule

// File: rtl/am_lock_rx.sv
// Receive alignment-marker lock for one PCS lane: finds the periodic marker,
// identifies its lane, locks after two in-period markers, drops on INV_MAX bad ones.
module am_lock_rx
    import am_pkg::*;
#(
    parameter int unsigned LANE_N  = 4,
    parameter int unsigned HEAD_W  = 2,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned AM_GAP  = 16383,
    parameter int unsigned INV_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    am_lock_rx_if.slave   bus
);

    localparam int unsigned LANE_W = (LANE_N > 1) ? $clog2(LANE_N) : 1;
    localparam int unsigned INV_W  = $clog2(INV_MAX + 1);

    am_state_t            r_state, w_state_nxt;
    logic [AM_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    lane_id_t             r_cur_lane, w_cur_lane_nxt;
    logic [INV_W-1:0]     r_inv_cnt, w_inv_cnt_nxt;
    logic                 r_lock, w_lock_nxt;
    logic [LANE_W-1:0]    r_lane, w_lane_nxt;
    logic                 r_marker_v, w_marker_v_nxt;
    logic                 r_valid;
    logic [HEAD_W-1:0]    r_head;
    logic [DATA_W-1:0]    r_data;

    logic                 w_hit;
    lane_id_t             w_hit_lane;
    logic                 w_slot;
    logic                 w_good;

    am_match #(.HEAD_W(HEAD_W), .DATA_W(DATA_W), .LANE_N(LANE_N)) u_match (
        .i_head     (bus.head_i),
        .i_data     (bus.data_i),
        .o_hit      (w_hit),
        .o_hit_lane (w_hit_lane)
    );

    assign w_slot = (r_cnt == AM_CNT_W'(AM_GAP));
    assign w_good = w_hit && (w_hit_lane == r_cur_lane);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_FIND;
        else       r_state <= w_state_nxt;
    end

    // Next state; every register holds while valid_i is low.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_lane_nxt = r_cur_lane;
        w_inv_cnt_nxt  = r_inv_cnt;
        w_lock_nxt     = r_lock;
        w_lane_nxt     = r_lane;
        w_marker_v_nxt = r_marker_v;
        if (bus.valid_i) begin
            w_cnt_nxt      = w_slot ? '0 : r_cnt + AM_CNT_W'(1);
            w_marker_v_nxt = 1'b0;
            case (r_state)
                ST_FIND: begin
                    if (w_hit) begin
                        w_cur_lane_nxt = w_hit_lane;
                        w_cnt_nxt      = '0;
                        w_inv_cnt_nxt  = '0;
                        w_state_nxt    = ST_COUNT_2ND;
                    end
                end
                ST_COUNT_2ND: begin
                    if (w_slot) w_state_nxt = w_good ? ST_LOCKED : ST_FIND;
                end
                ST_LOCKED: begin
                    if (w_slot) begin
                        w_marker_v_nxt = 1'b1;
                        if (w_good) begin
                            w_inv_cnt_nxt = '0;
                        end else if (r_inv_cnt == INV_W'(INV_MAX - 1)) begin
                            w_inv_cnt_nxt = '0;
                            w_state_nxt   = ST_FIND;
                        end else begin
                            w_inv_cnt_nxt = r_inv_cnt + INV_W'(1);
                        end
                    end
                end
                default: w_state_nxt = ST_FIND;
            endcase
            w_lock_nxt = (w_state_nxt == ST_LOCKED);
            w_lane_nxt = w_lock_nxt ? LANE_W'(r_cur_lane) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_cur_lane <= '0;
            r_inv_cnt  <= '0;
            r_lock     <= 1'b0;
            r_lane     <= '0;
            r_marker_v <= 1'b0;
            r_valid    <= 1'b0;
            r_head     <= '0;
            r_data     <= '0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_cur_lane <= w_cur_lane_nxt;
            r_inv_cnt  <= w_inv_cnt_nxt;
            r_lock     <= w_lock_nxt;
            r_lane     <= w_lane_nxt;
            r_marker_v <= w_marker_v_nxt;
            r_valid    <= bus.valid_i;
            if (bus.valid_i) begin
                r_head <= bus.head_i;
                r_data <= bus.data_i;
            end
        end
    end

    assign bus.valid_o    = r_valid;
    assign bus.head_o     = r_head;
    assign bus.data_o     = r_data;
    assign bus.lock_o     = r_lock;
    assign bus.lane_o     = r_lane;
    assign bus.marker_v_o = r_marker_v;

endmodule

// File: tb/tb_am_lock_rx.sv
// Directed bench for am_lock_rx with a 16-block marker period (AM_GAP = 15).
module tb_am_lock_rx;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    am_lock_rx_if #(.LANE_N(4), .HEAD_W(2), .DATA_W(64)) bus ();

    am_lock_rx #(
        .LANE_N(4), .HEAD_W(2), .DATA_W(64), .AM_GAP(15), .INV_MAX(4)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Marker block for a lane: {BIP7, ~M2, ~M1, ~M0, BIP3, M2, M1, M0}.
    function automatic logic [63:0] mk(input int l);
        logic [23:0] m;
        case (l)
            0:       m = 24'h477690;
            1:       m = 24'hE6C4F0;
            2:       m = 24'h9B65C5;
            default: m = 24'h3D79A2;
        endcase
        return {8'h5A, ~m, 8'hA5, m};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One block in, then sample the registered outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d);
        bus.valid_i = v;
        bus.head_i  = h;
        bus.data_i  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic lk, input logic [1:0] ln, input logic mv);
        chk({tag, ".lock"},     64'(bus.lock_o),     64'(lk));
        chk({tag, ".lane"},     64'(bus.lane_o),     64'(ln));
        chk({tag, ".marker_v"}, 64'(bus.marker_v_o), 64'(mv));
    endtask

    task automatic gap(input string tag, input int n, input logic lk, input logic [1:0] ln);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 2'b01, {$urandom, $urandom});
            expect_st(tag, lk, ln, 1'b0);
        end
    endtask

    task automatic marker(input string tag, input logic [63:0] d,
                          input logic lk, input logic [1:0] ln, input logic mv);
        step(1'b1, 2'b10, d);
        expect_st(tag, lk, ln, mv);
        chk({tag, ".data_o"}, bus.data_o, d);
    endtask

    logic [63:0] bad0;

    initial begin
        bad0 = mk(0) ^ 64'h0000_0000_0000_FF00;

        // Reset state
        rst = 1'b1;
        step(1'b0, 2'b00, 64'h0);
        step(1'b0, 2'b00, 64'h0);
        expect_st("reset", 1'b0, 2'd0, 1'b0);
        chk("reset.valid_o", 64'(bus.valid_o), 64'd0);
        chk("reset.head_o",  64'(bus.head_o),  64'd0);
        chk("reset.data_o",  bus.data_o,       64'd0);
        rst = 1'b0;

        // Clean acquire on lane 2
        marker("acq.m1", mk(2), 1'b0, 2'd0, 1'b0);
        chk("acq.valid_o", 64'(bus.valid_o), 64'd1);
        chk("acq.head_o",  64'(bus.head_o),  64'd2);
        gap("acq.gap1", 15, 1'b0, 2'd0);
        marker("acq.m2", mk(2), 1'b1, 2'd2, 1'b0);
        gap("acq.gap2", 15, 1'b1, 2'd2);
        marker("acq.m3", mk(2), 1'b1, 2'd2, 1'b1);

        // Stall 7 cycles mid-period: slot moves by 7, lock holds
        gap("stall.pre", 5, 1'b1, 2'd2);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 2'b10, mk(2));
            chk("stall.valid_o", 64'(bus.valid_o), 64'd0);
            expect_st("stall.hold", 1'b1, 2'd2, 1'b0);
        end
        gap("stall.post", 10, 1'b1, 2'd2);
        marker("stall.m", mk(2), 1'b1, 2'd2, 1'b1);

        // Reset while locked, then reacquire on lane 0
        rst = 1'b1;
        step(1'b1, 2'b10, mk(2));
        expect_st("rstlk", 1'b0, 2'd0, 1'b0);
        chk("rstlk.valid_o", 64'(bus.valid_o), 64'd0);
        chk("rstlk.data_o",  bus.data_o,       64'd0);
        rst = 1'b0;
        marker("relk.m1", mk(0), 1'b0, 2'd0, 1'b0);
        gap("relk.gap", 15, 1'b0, 2'd0);
        marker("relk.m2", mk(0), 1'b1, 2'd0, 1'b0);

        // Three bad markers then a good one: lock held
        for (int k = 0; k < 3; k++) begin
            gap("bad3.gap", 15, 1'b1, 2'd0);
            marker("bad3.m", bad0, 1'b1, 2'd0, 1'b1);
        end
        gap("bad3.gap", 15, 1'b1, 2'd0);
        marker("bad3.good", mk(0), 1'b1, 2'd0, 1'b1);

        // Four bad markers: lock drops on the fourth, which is still flagged
        for (int k = 0; k < 3; k++) begin
            gap("loss.gap", 15, 1'b1, 2'd0);
            marker("loss.m", bad0, 1'b1, 2'd0, 1'b1);
        end
        gap("loss.gap", 15, 1'b1, 2'd0);
        marker("loss.m4", bad0, 1'b0, 2'd0, 1'b1);

        // Wrong second marker returns to FIND without re-seeding on it
        gap("wrong.pre", 3, 1'b0, 2'd0);
        marker("wrong.m1", mk(1), 1'b0, 2'd0, 1'b0);
        gap("wrong.gap", 15, 1'b0, 2'd0);
        marker("wrong.m3", mk(3), 1'b0, 2'd0, 1'b0);
        gap("wrong.gap2", 7, 1'b0, 2'd0);
        marker("wrong.n1", mk(1), 1'b0, 2'd0, 1'b0);
        gap("wrong.gap3", 15, 1'b0, 2'd0);
        marker("wrong.n2", mk(1), 1'b1, 2'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
